alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle controller that shares the single combinational ALU between two requesters (e.g. the instruction pipeline and the calculator's microcode engine). It arbitrates requests round-robin, registers the operands and drives the ALU for one or more cycles. Multiply is given a configurable settling time. It returns the registered result and flags through a valid/ready response port, and maintains the architectural Z/N flag register.

## Interface
- MUL_CYCLES, 3, cycles the ALU inputs are held for control=2 (multiply); legal range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  ALU control code (0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr)
- req0_a, req0_b  in  32  operands (dat1, dat2)
- req0_set  in  1  operation updates flag_Z/flag_N
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_set: same as requester 0
- alu_dat1, alu_dat2  out  32  ALU operands
- alu_control  out  4  ALU operation select
- alu_set  out  1  ALU flag-update enable
- alu_result  in  32  ALU result
- alu_Z, alu_N  in  1  ALU zero/negative outputs
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  32  registered result
- rsp_Z, rsp_N  out  1  flags of this result, computed regardless of set
- flag_Z, flag_N  out  1  architectural flags; update only on set=1 operations

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester. reqN_ready=1 combinationally for the granted requester only. Capture op/a/b/set and id. Load cnt = (op==2) ? MUL_CYCLES-1 : 0. Go to EXEC. Both ready outputs are 0 in EXEC and RESP.
- Arbitration: round-robin on last_grant. When both requesters are valid, grant the one not granted last. A single valid requester is granted regardless of last_grant. last_grant updates at grant.
- EXEC: alu_dat1/alu_dat2/alu_control = captured values and alu_set = captured set. If cnt!=0, decrement and stay. If cnt==0, register alu_result into rsp_result and alu_Z/alu_N into rsp_Z/rsp_N, then go to RESP.
- Flag register: when the EXEC capture happens with set=1, flag_Z<=alu_Z and flag_N<=alu_N in the same edge. Otherwise flags hold.
- RESP: rsp_valid=1 and rsp_id/rsp_result/rsp_Z/rsp_N are stable. On rsp_valid&&rsp_ready, go to IDLE. With rsp_ready low, hold indefinitely.
- Outside EXEC: alu_* hold the last captured operands and alu_set=0.
- Codes 6..15 are forwarded unchanged. Whatever the ALU returns is reported (0xFFFFFFFF, Z=0, N=1). No error signalling.
- Request inputs are sampled only at grant. Later changes do not affect an operation already accepted.

## Timing
- Reset (asynchronous, any state): state=IDLE, cnt=0, last_grant=1 (requester 0 wins the first tie). All outputs 0: rsp_*, flag_Z, flag_N, alu_dat1/2, alu_control, alu_set. An in-flight operation is discarded with no response. Flags return to 0.
- Accept edge T (valid&&ready in IDLE): EXEC during T+1.
- Non-multiply: result registered at edge T+2. rsp_valid high from cycle T+2.
- Multiply: EXEC occupies MUL_CYCLES cycles. rsp_valid high from cycle T+1+MUL_CYCLES.
- Response handshake at edge R: IDLE at R+1. The next accept is at R+1 at the earliest.
- Peak throughput is one non-multiply operation per 3 cycles.
- No combinational path from rsp_ready to reqN_ready. reqN_ready depends only on state, valids and last_grant.

## Test plan
- Single add: req0 op=0 a=5 b=7 set=1, rsp_ready=1 → req0_ready pulses 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=12, rsp_Z=0, rsp_N=0; flag_Z=0, flag_N=0.
- Contention: both valid continuously with ops sub 3-3 (req0) and or 0x0F|0xF0 (req1) → grants alternate 0,1,0,1. req0 responses 0 with Z=1; req1 responses 0xFF.
- Multiply latency, MUL_CYCLES=3: req1 mul 0x10000*0x10000 set=1 → ALU inputs held 3 cycles; rsp_valid at accept+4; rsp_result=0, rsp_Z=1, flag_Z=1.
- Set gating: sub 1-2 set=0 after a Z-setting operation → rsp_result=0xFFFFFFFF, rsp_N=1; flag_Z stays 1 and flag_N stays 0.
- Backpressure: rsp_ready low 5 cycles with req0 pending → rsp fields stable; req0_ready stays 0 until the cycle after the response handshake.
- Reset mid-multiply: assert rst during EXEC → all outputs 0 immediately. After release, req0 lsl 1<<4 gives result 16 with rsp_id=0 and no stale response.

Source files
------------

// File: rtl/alu_sequencer.sv
// Shares one external combinational ALU between two requesters: round-robin grant,
// registered operands, multi-cycle multiply hold, valid/ready response and Z/N flags.
module alu_sequencer #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_set,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_set,
    output logic [31:0] alu_dat1,
    output logic [31:0] alu_dat2,
    output logic [3:0]  alu_control,
    output logic        alu_set,
    input  logic [31:0] alu_result,
    input  logic        alu_Z,
    input  logic        alu_N,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_Z,
    output logic        rsp_N,
    output logic        flag_Z,
    output logic        flag_N
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        cap_id;
    logic        cap_set;
    logic        grant;
    logic        grant_id;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_set;

    // Grant decode depends only on state, valids and last_grant (never on rsp_ready).
    always_comb begin
        grant    = (state == IDLE) && (req0_valid || req1_valid);
        grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_op   = grant_id ? req1_op  : req0_op;
        sel_a    = grant_id ? req1_a   : req0_a;
        sel_b    = grant_id ? req1_b   : req0_b;
        sel_set  = grant_id ? req1_set : req0_set;
    end

    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant && grant_id;
    assign rsp_valid  = (state == RESP);
    assign alu_set    = (state == EXEC) && cap_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            cap_id      <= 1'b0;
            cap_set     <= 1'b0;
            alu_dat1    <= 32'd0;
            alu_dat2    <= 32'd0;
            alu_control <= 4'd0;
            rsp_id      <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_Z       <= 1'b0;
            rsp_N       <= 1'b0;
            flag_Z      <= 1'b0;
            flag_N      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_grant  <= grant_id;
                        cap_id      <= grant_id;
                        cap_set     <= sel_set;
                        alu_dat1    <= sel_a;
                        alu_dat2    <= sel_b;
                        alu_control <= sel_op;
                        cnt         <= (sel_op == 4'd2) ? MUL_LOAD : 4'd0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_id     <= cap_id;
                        rsp_result <= alu_result;
                        rsp_Z      <= alu_Z;
                        rsp_N      <= alu_N;
                        if (cap_set) begin
                            flag_Z <= alu_Z;
                            flag_N <= alu_N;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with a behavioural ALU attached
// to the alu_* port; corner cases (contention, backpressure, reset) are hand sequences.
module tb_alu_sequencer;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        set;
        logic [31:0] exp_res;
        logic        exp_z;
        logic        exp_n;
        logic        exp_fz;
        logic        exp_fn;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic        req0_set = 1'b0, req1_set = 1'b0;
    logic [31:0] alu_dat1, alu_dat2, alu_result;
    logic [3:0]  alu_control;
    logic        alu_set, alu_Z, alu_N;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_Z, rsp_N;
    logic [31:0] rsp_result;
    logic        flag_Z, flag_N;

    int checks = 0;
    int failures = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_sequencer #(.MUL_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_set(req0_set),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_set(req1_set),
        .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_control(alu_control),
        .alu_set(alu_set), .alu_result(alu_result), .alu_Z(alu_Z), .alu_N(alu_N),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_Z(rsp_Z), .rsp_N(rsp_N),
        .flag_Z(flag_Z), .flag_N(flag_N)
    );

    // Stand-in for the shared ALU; unknown codes return all ones.
    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_dat1 + alu_dat2;
            4'd1:    alu_result = alu_dat1 - alu_dat2;
            4'd2:    alu_result = alu_dat1 * alu_dat2;
            4'd3:    alu_result = alu_dat1 | alu_dat2;
            4'd4:    alu_result = alu_dat1 << alu_dat2[4:0];
            4'd5:    alu_result = alu_dat1 >> alu_dat2[4:0];
            default: alu_result = 32'hFFFF_FFFF;
        endcase
        alu_Z = (alu_result == 32'd0);
        alu_N = alu_result[31];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic dropRequests();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = 32'hDEAD_BEEF;
        req1_a = 32'hDEAD_BEEF;
        req0_op = 4'd3;
        req1_op = 4'd3;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit got = 0;
        int lat = 1;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_set = v.set;
        end else begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_set = v.set;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checkOutput("grant_timeout", 32'd0, 32'd1);
            dropRequests();
            return;
        end
        @(posedge clk);
        @(negedge clk);
        dropRequests();
        checkOutput("ready_low_in_exec", {30'd0, req0_ready, req1_ready}, 32'd0);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, v.exp_lat);
        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
        checkOutput("rsp_result", rsp_result, v.exp_res);
        checkOutput("rsp_Z", {31'd0, rsp_Z}, {31'd0, v.exp_z});
        checkOutput("rsp_N", {31'd0, rsp_N}, {31'd0, v.exp_n});
        checkOutput("flag_Z", {31'd0, flag_Z}, {31'd0, v.exp_fz});
        checkOutput("flag_N", {31'd0, flag_N}, {31'd0, v.exp_fn});
        @(negedge clk);
        checkOutput("rsp_valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int grants[$];
        int rsps;
        logic [31:0] held_res;
        bit got;
        vec_t last;

        vecs[0] = '{1'b0, 4'd0, 32'd5,          32'd7,    1'b1, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b1, 4'd2, 32'h0001_0000,  32'h0001_0000, 1'b1, 32'd0,     1'b1, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{1'b0, 4'd1, 32'd1,          32'd2,    1'b0, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b1, 4'd3, 32'h0F,         32'hF0,   1'b1, 32'hFF,         1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[4] = '{1'b0, 4'd5, 32'h8000_0000,  32'd4,    1'b1, 32'h0800_0000,  1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[5] = '{1'b1, 4'd9, 32'd1,          32'd1,    1'b1, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 1'b1, 2};
        vecs[6] = '{1'b0, 4'd4, 32'd1,          32'd31,   1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1, 2};
        vecs[7] = '{1'b1, 4'd1, 32'd3,          32'd3,    1'b1, 32'd0,          1'b1, 1'b0, 1'b1, 1'b0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_flags", {30'd0, flag_Z, flag_N}, 32'd0);
        checkOutput("reset_alu_ctrl", {27'd0, alu_control, alu_set}, 32'd0);
        checkOutput("reset_alu_dat1", alu_dat1, 32'd0);
        checkOutput("reset_rsp_result", rsp_result, 32'd0);
        checkOutput("reset_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Contention: both valid continuously, first tie after reset goes to requester 0
        doReset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd3;   req0_b = 32'd3;   req0_set = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'h0F;  req1_b = 32'hF0;  req1_set = 1'b0;
        rsps = 0;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                rsps++;
                checkOutput("contend_result", rsp_result, rsp_id ? 32'hFF : 32'd0);
                checkOutput("contend_Z", {31'd0, rsp_Z}, rsp_id ? 32'd0 : 32'd1);
            end
            @(negedge clk);
        end
        dropRequests();
        checkOutput("contend_grant_count_ge4", {31'd0, grants.size() >= 4}, 32'd1);
        checkOutput("contend_rsp_count_ge4", {31'd0, rsps >= 4}, 32'd1);
        if (grants.size() >= 4) begin
            checkOutput("contend_grant_order", {grants[0][7:0], grants[1][7:0], grants[2][7:0], grants[3][7:0]},
                        32'h00010001);
        end
        repeat (8) @(negedge clk);

        // Backpressure with req0 still pending behind the held response
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd2; req0_b = 32'd5; req0_set = 1'b1;
        #1;
        checkOutput("bp_first_grant", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1; req0_set = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin got = 1; break; end
            @(negedge clk);
        end
        checkOutput("bp_rsp_seen", {31'd0, got}, 32'd1);
        held_res = rsp_result;
        checkOutput("bp_result", held_res, 32'hFFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_stable", {rsp_result[27:0], rsp_valid, rsp_id, rsp_Z, rsp_N},
                        {held_res[27:0], 1'b1, 1'b0, 1'b0, 1'b1});
            checkOutput("bp_req0_ready_low", {31'd0, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_ready_low_at_handshake", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("bp_ready_after_handshake", {31'd0, req0_ready}, 32'd1);
        checkOutput("bp_flag_N", {31'd0, flag_N}, 32'd1);
        @(negedge clk);
        dropRequests();
        @(negedge clk);
        #1;
        checkOutput("bp_second_result", rsp_result, 32'd2);
        checkOutput("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);

        // Reset in the middle of a multiply discards it and clears everything
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'h0001_0000; req0_b = 32'd3; req0_set = 1'b1;
        @(negedge clk);
        dropRequests();
        @(negedge clk);
        checkOutput("mid_mul_alu_set", {31'd0, alu_set}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_alu_dat", alu_dat1 | alu_dat2, 32'd0);
        checkOutput("rst_alu_ctrl", {27'd0, alu_control, alu_set}, 32'd0);
        checkOutput("rst_rsp", {rsp_result[28:0], rsp_valid, rsp_Z, rsp_N}, 32'd0);
        checkOutput("rst_flags", {30'd0, flag_Z, flag_N}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last = '{1'b0, 4'd4, 32'd1, 32'd4, 1'b0, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        applyStimulus(last);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
